// File: rtl/fp16_mul_arbiter.sv
// Round-robin front end that shares one pipelined FP16 multiplier between NREQ requesters.
// Each issued operand pair carries its requester ID through a tag pipe matched to the multiplier depth.
module fp16_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [15:0]        mul_result,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [15:0]        resp_data,
  output logic               busy
);

  localparam int unsigned DW = 16;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_next;
  logic               grant;
  logic [IDW-1:0]     grant_id;
  logic [DW-1:0]      grant_a;
  logic [DW-1:0]      grant_b;
  logic               issue_valid;
  logic [IDW-1:0]     issue_id;
  logic [LATENCY-1:0] tag_valid;
  logic [IDW-1:0]     tag_id [LATENCY];

  // First valid requester at or after the pointer wins; the search wraps mod NREQ.
  always_comb begin : grant_search
    int unsigned idx;
    req_ready = '0;
    grant     = 1'b0;
    grant_id  = '0;
    grant_a   = '0;
    grant_b   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!hold && !grant && req_valid[idx]) begin
        grant          = 1'b1;
        grant_id       = IDW'(idx);
        req_ready[idx] = 1'b1;
        grant_a        = req_a[DW*idx +: DW];
        grant_b        = req_b[DW*idx +: DW];
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (grant) begin
      ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Issue stage: operands stay put between transfers, only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      issue_valid <= 1'b0;
      issue_id    <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      issue_valid <= grant;
      ptr         <= ptr_next;
      if (grant) begin
        issue_id <= grant_id;
        mul_a    <= grant_a;
        mul_b    <= grant_b;
      end
    end
  end

  // Tag pipe tracks the multiplier stages one-for-one; the multiplier never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_valid[0] <= issue_valid;
      tag_id[0]    <= issue_id;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign resp_valid = tag_valid[LATENCY-1];
  assign resp_id    = tag_id[LATENCY-1];
  assign resp_data  = mul_result;
  assign busy       = issue_valid | (|tag_valid);

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed and scoreboarded checks of fp16_mul_arbiter against a behavioural FP16 multiplier pipe.
module tb_fp16_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int LATENCY = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    data;
    int             due;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               hold = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*16-1:0] req_a = '0;
  logic [NREQ*16-1:0] req_b = '0;
  logic [NREQ-1:0]    req_ready;
  logic [15:0]        mul_a;
  logic [15:0]        mul_b;
  logic [15:0]        mul_result;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [15:0]        resp_data;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  fp16_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Round-to-nearest-even product, valid for normal operands and zeros.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [21:0] p;
    logic [10:0] m;
    logic        g;
    logic        st;
    logic [11:0] mr;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'h0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[21:11]; g = p[10]; st = |p[9:0]; e++;
    end else begin
      m = p[20:10]; g = p[9]; st = |p[8:0];
    end
    mr = {1'b0, m} + ((g && (st || m[0])) ? 12'd1 : 12'd0);
    if (mr[11]) begin
      mr = mr >> 1; e++;
    end
    return {s, 5'(e), mr[9:0]};
  endfunction

  function automatic logic [15:0] rand_fp();
    if ($urandom_range(0, 15) == 0) return {1'($urandom_range(0, 1)), 15'h0};
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
  endfunction

  // Stand-in for the shared multiplier: LATENCY register stages.
  logic [15:0] mpipe [LATENCY];
  always @(posedge clk) begin
    mpipe[0] <= fp16_mul(mul_a, mul_b);
    for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[LATENCY-1];

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    req_valid = '0;
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_id !== '0) begin bad++; $display("FAIL reset_resp_id got=%0d want=0", resp_id); end
    total++; if (mul_a !== 16'h0000) begin bad++; $display("FAIL reset_mul_a got=%h want=0000", mul_a); end
    total++; if (mul_b !== 16'h0000) begin bad++; $display("FAIL reset_mul_b got=%h want=0000", mul_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_a[15:0] = 16'h4200;
    req_b[15:0] = 16'h4000;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      total++; if (resp_valid !== (i == 2)) begin bad++; $display("FAIL single_resp_valid i=%0d got=%b want=%b", i, resp_valid, i == 2); end
      total++; if (busy !== (i < 3)) begin bad++; $display("FAIL single_busy i=%0d got=%b want=%b", i, busy, i < 3); end
      if (i == 2) begin
        total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d want=0", resp_id); end
        total++; if (resp_data !== 16'h4600) begin bad++; $display("FAIL single_data got=%h want=4600", resp_data); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] want [4];
    want = '{16'hC600, 16'h4400, 16'h0000, 16'h4600};
    do_reset();
    req_a = {16'h4200, 16'h4200, 16'hC000, 16'hC200};
    req_b = {16'h4000, 16'h0000, 16'hC000, 16'h4000};
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 5) begin
        total++; if (req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, req_ready, 4'(1 << (c % 4))); end
      end
      tick();
      total++; if (resp_valid !== (c >= 2 && c <= 6)) begin bad++; $display("FAIL rr_resp_valid c=%0d got=%b", c, resp_valid); end
      if (c >= 2 && c <= 6) begin
        total++; if (resp_id !== IDW'((c - 2) % 4)) begin bad++; $display("FAIL rr_id c=%0d got=%0d want=%0d", c, resp_id, (c - 2) % 4); end
        total++; if (resp_data !== want[(c - 2) % 4]) begin bad++; $display("FAIL rr_data c=%0d got=%h want=%h", c, resp_data, want[(c - 2) % 4]); end
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL fair_first got=%b want=0010", req_ready); end
    tick();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (req_ready !== ((i % 2 == 0) ? 4'b1000 : 4'b0010)) begin bad++; $display("FAIL fair_ready i=%0d got=%b", i, req_ready); end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 10 && busy; k++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_drain busy=%b want=0", busy); end
  endtask

  task automatic test_hold();
    req_a[47:32] = 16'h4200;
    req_b[47:32] = 16'h4200;
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL hold_pre_ready got=%b want=0100", req_ready); end
    tick();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL hold_ready i=%0d got=%b want=0000", i, req_ready); end
      total++; if (busy !== (i < 3)) begin bad++; $display("FAIL hold_busy i=%0d got=%b want=%b", i, busy, i < 3); end
      total++; if (resp_valid !== (i == 2)) begin bad++; $display("FAIL hold_resp_valid i=%0d got=%b", i, resp_valid); end
      if (i == 2) begin
        total++; if (resp_id !== 2'd2 || resp_data !== 16'h4880) begin bad++; $display("FAIL hold_resp got=%0d/%h want=2/4880", resp_id, resp_data); end
      end
      tick();
    end
    hold = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL hold_resume got=%b want=1000", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 10 && busy; k++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_drain busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'(1 << c)) begin bad++; $display("FAIL rmid_ready c=%0d got=%b", c, req_ready); end
      tick();
    end
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async got=%b/%b want=0/0", resp_valid, busy); end
    total++; if (mul_a !== 16'h0000) begin bad++; $display("FAIL rmid_mul_a got=%h want=0000", mul_a); end
    #1;
    rst = 1'b0;
    for (int i = 0; i <= LATENCY; i++) begin
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale i=%0d got=%b want=0", i, resp_valid); end
    end
    req_a[47:32] = 16'hC000;
    req_b[47:32] = 16'h3800;
    req_valid = 4'b1100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmid_ptr got=%b want=0100", req_ready); end
    tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      total++; if (resp_valid !== (i == 2)) begin bad++; $display("FAIL rmid_resp_valid i=%0d got=%b", i, resp_valid); end
      if (i == 2) begin
        total++; if (resp_id !== 2'd2 || resp_data !== 16'hBC00) begin bad++; $display("FAIL rmid_resp got=%0d/%h want=2/bc00", resp_id, resp_data); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    exp_t            q[$];
    exp_t            e;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] exp_ready;
    logic [15:0]     pa [NREQ];
    logic [15:0]     pb [NREQ];
    int              mptr;
    int              g;
    do_reset();
    mptr = 0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin pa[i] = 16'h0; pb[i] = 16'h0; end
    for (int c = 0; c < 2000 + LATENCY + 3; c++) begin
      if (c < 2000) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(0, 9) < 4) begin
            pend[i] = 1'b1; pa[i] = rand_fp(); pb[i] = rand_fp();
          end
        end
        hold = ($urandom_range(0, 9) == 0);
        req_valid = pend;
      end else begin
        hold = 1'b0;
        req_valid = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        req_a[16*i +: 16] = pa[i];
        req_b[16*i +: 16] = pb[i];
      end
      g = -1;
      if (!hold && c < 2000) begin
        for (int k = 0; k < NREQ; k++) if (g < 0 && pend[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      #1;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
      if (g >= 0) begin
        e.id = IDW'(g); e.data = fp16_mul(pa[g], pb[g]); e.due = cycle + 1 + LATENCY;
        q.push_back(e);
        pend[g] = 1'b0;
        mptr = (g + 1) % NREQ;
      end
      tick();
      total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, q.size() != 0); end
      if (q.size() > 0 && q[0].due == cycle) begin
        e = q.pop_front();
        total++;
        if (resp_valid !== 1'b1 || resp_id !== e.id || resp_data !== e.data) begin
          bad++; $display("FAIL rand_resp c=%0d got=%b/%0d/%h want=1/%0d/%h", c, resp_valid, resp_id, resp_data, e.id, e.data);
        end
      end else begin
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rand_spurious c=%0d resp_valid=%b want=0", c, resp_valid); end
      end
    end
    total++; if (q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rand_end left=%0d busy=%b want=0/0", q.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
